rcounter_display_scan: RTL
==========================

// Module: rcounter_display_scan
// PURPOSE
//  Display-side consumer of the countdown commander's time/edit outputs. Drives a
//  6-digit multiplexed 7-segment display: MM.SS.CC (min, sec, 10 ms, packed BCD).
//  Blinks the field selected by target while editing, and blinks all digits on
//  time-out. Sits between the commander and the board's anode/cathode pins.
// PARAMETERS
//  SCAN_DIV   100000    clk_core cycles each digit stays lit (>=2)
//  BLINK_DIV  25000000  clk_core cycles per blink half-period (>=2)
// PORTS
//  clk_core    in   1  core clock, all logic on rising edge
//  rst         in   1  asynchronous active-high reset
//  min_i       in   8  minutes, packed BCD {tens,units}
//  sec_i       in   8  seconds, packed BCD
//  ms_10_i     in   8  hundredths of a second, packed BCD
//  target_i    in   2  edit field: 00 none, 01 ms_10, 10 sec, 11 min
//  time_out_i  in   1  countdown expired; all digits blink
//  an_o        out  6  digit enables, active low, bit k = digit k
//  seg_o       out  8  {dp,g,f,e,d,c,b,a}, active low
// BEHAVIOUR
//  - Digit map: 0 ms_10[3:0], 1 ms_10[7:4], 2 sec[3:0], 3 sec[7:4],
//    4 min[3:0], 5 min[7:4]. DP lit on digits 2 and 4 only.
//  - Reset (async): scan_cnt=0, digit_idx=0, blink_cnt=0, blink_ph=0, snapshot
//    regs (min/sec/ms_10/target/time_out)=0, an_o=6'h3F, seg_o=8'hFF.
//  - scan_cnt counts 0..SCAN_DIV-1 and wraps. At the terminal count,
//    digit_idx advances 0->1->...->5->0.
//  - Snapshot: all five inputs are registered only when digit_idx wraps 5->0,
//    in the same cycle. A frame (6*SCAN_DIV cycles) never mixes old and new
//    values. Mid-frame input changes are invisible until the next frame.
//  - blink_cnt counts 0..BLINK_DIV-1. blink_ph toggles at the terminal count.
//    The blink runs free and is not reset by target or time_out changes.
//  - Outputs are registered with 1-cycle latency:
//    an_o = ~(6'b1 << digit_idx) and seg_o = f(digit_idx, snapshot, blink_ph),
//    both taken from the previous cycle's values.
//  - blank = blink_ph & (snap_time_out | digit_idx in the snap_target field).
//    target 00 never blanks.
//  - seg_o = 8'hFF when blank (dp off too). an_o stays asserted.
//  - Decode, a..g active low:
//    0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
//  - A nibble >9 shows a dash: 8'hBF.
//  - DP: clear bit 7 on digits 2 and 4 (e.g. '4' -> 8'h19).
//  - At most one an_o bit is low at any time. Out of reset, exactly one bit is
//    always low.
//  - Reset asserted mid-scan returns an_o=3F, seg_o=FF immediately.
//    Scanning restarts at digit 0 on the first edge after release.
// TESTING (bench uses SCAN_DIV=4, BLINK_DIV=16)
//  1 Reset held -> an_o=3F, seg_o=FF. First edge after release ->
//    an_o=3E, seg_o=C0.
//  2 min=12 sec=34 ms_10=56 target=00, wait one full frame -> digits 0..5 show
//    seg 82,92,19,B0,24,F9. Each an_o value is held exactly 4 cycles.
//    Frame = 24 cycles.
//  3 target=10, same time -> digits 2,3 show FF while blink_ph=1
//    (16 of every 32 cycles) and 19,B0 otherwise. Other digits are unaffected.
//  4 time_out=1 -> all six digits FF while blink_ph=1 and normal decode
//    while blink_ph=0.
//  5 ms_10=8'hA5 -> digit0 92, digit1 BF (dash). Change sec mid-frame ->
//    digits 2,3 keep the old value until digit_idx wraps 5->0.
//  6 Assert rst during digit 3 -> an_o=3F, seg_o=FF asynchronously.
//    After release the scan restarts at digit 0 with the snapshot cleared
//    (seg C0).

Source files
------------

// File: rtl/rcounter_display_scan_if.sv
// Commander-to-display bundle: time/edit state toward the scanner, pin drives back out.
interface rcounter_display_scan_if;
    logic [7:0] min_i;
    logic [7:0] sec_i;
    logic [7:0] ms_10_i;
    logic [1:0] target_i;
    logic       time_out_i;
    logic [5:0] an_o;
    logic [7:0] seg_o;

    modport master (
        output min_i, sec_i, ms_10_i, target_i, time_out_i,
        input  an_o, seg_o
    );

    modport slave (
        input  min_i, sec_i, ms_10_i, target_i, time_out_i,
        output an_o, seg_o
    );
endinterface

// File: rtl/rcounter_display_scan.sv
// 6-digit multiplexed 7-segment scanner for MM.SS.CC with field/time-out blinking.
// Inputs are snapshotted once per frame so a frame never mixes old and new time.
module rcounter_display_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk_core,
    input  logic                  rst,
    rcounter_display_scan_if.slave bus
);
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] scan_cnt_q,  scan_cnt_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q,  blink_ph_d;
    logic [7:0]    snap_min_q,  snap_sec_q, snap_ms_q;
    logic [1:0]    snap_tgt_q;
    logic          snap_to_q;
    logic [5:0]    an_q,  an_d;
    logic [7:0]    seg_q, seg_d;

    logic          scan_tc;
    logic          frame_wrap;
    logic          blink_tc;
    logic [3:0]    nib;
    logic          field_hit;
    logic          blank;

    function automatic logic [7:0] decode7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_tc     = (scan_cnt_q == SW'(SCAN_DIV - 1));
        frame_wrap  = scan_tc && (digit_idx_q == 3'd5);
        blink_tc    = (blink_cnt_q == BW'(BLINK_DIV - 1));

        scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SW'(1);
        digit_idx_d = digit_idx_q;
        if (scan_tc) digit_idx_d = (digit_idx_q == 3'd5) ? 3'd0 : digit_idx_q + 3'd1;
        blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BW'(1);
        blink_ph_d  = blink_tc ? ~blink_ph_q : blink_ph_q;

        case (digit_idx_q)
            3'd0:    nib = snap_ms_q[3:0];
            3'd1:    nib = snap_ms_q[7:4];
            3'd2:    nib = snap_sec_q[3:0];
            3'd3:    nib = snap_sec_q[7:4];
            3'd4:    nib = snap_min_q[3:0];
            default: nib = snap_min_q[7:4];
        endcase

        // digit pairs {0,1},{2,3},{4,5} map to target codes 01,10,11
        field_hit = (snap_tgt_q != 2'b00) && (snap_tgt_q == digit_idx_q[2:1] + 2'd1);
        blank     = blink_ph_q && (snap_to_q || field_hit);

        an_d  = ~(6'b000001 << digit_idx_q);
        seg_d = decode7(nib);
        if (digit_idx_q == 3'd2 || digit_idx_q == 3'd4) seg_d[7] = 1'b0;
        if (blank) seg_d = 8'hFF;
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            snap_min_q  <= '0;
            snap_sec_q  <= '0;
            snap_ms_q   <= '0;
            snap_tgt_q  <= '0;
            snap_to_q   <= 1'b0;
            an_q        <= 6'h3F;
            seg_q       <= 8'hFF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            if (frame_wrap) begin
                snap_min_q <= bus.min_i;
                snap_sec_q <= bus.sec_i;
                snap_ms_q  <= bus.ms_10_i;
                snap_tgt_q <= bus.target_i;
                snap_to_q  <= bus.time_out_i;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.an_o  = an_q;
    assign bus.seg_o = seg_q;
endmodule
